// File: rtl/if_stage_pkg.sv
// Shared fetch/decode types: the IF->ID bus, exception record, flush vector and PC helpers.
package if_stage_pkg;

  typedef logic [31:0] virt_t;

  localparam virt_t      RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [4:0] EXCCODE_ADEL     = 5'h04;

  typedef struct packed {
    logic       ex;
    logic       bd;
    logic       tlb_refill;
    logic [4:0] exccode;
    virt_t      badvaddr;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    virt_t       pc;
    exception_t  exception;
  } fs_to_ds_bus_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic cache_op;
  } pipeline_flush_t;

  function automatic logic flush_any(input pipeline_flush_t f);
    return f.ex | f.eret | f.tlb_op | f.cache_op;
  endfunction

  function automatic logic pc_aligned(input virt_t pc);
    return pc[1:0] == 2'b00;
  endfunction

  function automatic fs_to_ds_bus_t fetch_entry(input logic [31:0] inst, input virt_t pc);
    fs_to_ds_bus_t e;
    e       = '0;
    e.valid = 1'b1;
    e.inst  = inst;
    e.pc    = pc;
    return e;
  endfunction

  // Instruction word is zero; ID sees only the exception.
  function automatic fs_to_ds_bus_t adel_entry(input virt_t pc);
    fs_to_ds_bus_t e;
    e                    = '0;
    e.valid              = 1'b1;
    e.pc                 = pc;
    e.exception.ex       = 1'b1;
    e.exception.exccode  = EXCCODE_ADEL;
    e.exception.badvaddr = pc;
    return e;
  endfunction

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// One-entry holding register between the instruction port and ID.
module fetch_buffer
  import if_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  fs_to_ds_bus_t entry_i,
  input  logic          drain_i,
  input  logic          clear_i,
  output logic          valid_o,
  output fs_to_ds_bus_t entry_o
);

  logic          valid_d, valid_q;
  fs_to_ds_bus_t entry_d, entry_q;

  // Clear beats load beats drain: a refill in the drain cycle keeps the entry alive.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (drain_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  always_comb begin
    entry_o       = valid_q ? entry_q : '0;
    entry_o.valid = valid_q;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding SRAM-like fetch port and a one-entry
// buffer towards ID, with redirect/flush cancellation and misaligned-PC exceptions.
module if_stage
  import if_stage_pkg::*;
#(
  parameter virt_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ds_allowin,
  input  logic            ds_br_op,
  output fs_to_ds_bus_t   fs_to_ds_bus,
  input  logic            br_redirect,
  input  virt_t           br_target,
  input  pipeline_flush_t pipeline_flush,
  input  virt_t           flush_target,
  output logic            inst_req,
  output logic [31:0]     inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [31:0]     inst_rdata
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_CANCEL} state_e;

  state_e        state_q;
  virt_t         pc_q;
  virt_t         fetch_pc_q;
  logic          adel_sent_q;

  logic          redirect;
  virt_t         redirect_pc;
  logic          buf_valid;
  logic          buf_free;
  logic          handshake;
  logic          fetch_accept;
  logic          fetch_done;
  logic          adel_load;
  fs_to_ds_bus_t buf_entry;
  fs_to_ds_bus_t load_entry;

  assign redirect    = br_redirect | flush_any(pipeline_flush);
  assign redirect_pc = flush_any(pipeline_flush) ? flush_target : br_target;

  assign buf_free  = !buf_valid || ds_allowin;
  assign handshake = buf_valid && ds_allowin;

  assign inst_req     = resetn && (state_q == S_REQ) && pc_aligned(pc_q) && buf_free;
  assign inst_addr    = pc_q;
  assign fetch_accept = inst_req && inst_addr_ok;

  // Data arriving alongside a redirect belongs to the wrong path and is dropped.
  assign fetch_done = (state_q == S_WAIT) && inst_data_ok && !redirect;

  // A misaligned PC produces exactly one AdEL entry, then fetch stalls until redirected.
  assign adel_load = (state_q == S_REQ) && !pc_aligned(pc_q) && !adel_sent_q && buf_free &&
                     !redirect;

  assign load_entry = adel_load ? adel_entry(pc_q) : fetch_entry(inst_rdata, fetch_pc_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      adel_sent_q <= 1'b0;
    end else begin
      if (adel_load) adel_sent_q <= 1'b1;
      unique case (state_q)
        S_REQ: begin
          // An address accepted in the redirect cycle is already in flight and must be drained.
          if (redirect) begin
            state_q <= fetch_accept ? S_CANCEL : S_REQ;
          end else if (fetch_accept) begin
            state_q    <= S_WAIT;
            fetch_pc_q <= pc_q;
            pc_q       <= pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            state_q <= inst_data_ok ? S_REQ : S_CANCEL;
          end else if (inst_data_ok) begin
            state_q <= S_REQ;
          end
        end
        S_CANCEL: begin
          if (inst_data_ok) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
      if (redirect) begin
        pc_q        <= redirect_pc;
        adel_sent_q <= 1'b0;
      end
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .load_i  (fetch_done | adel_load),
    .entry_i (load_entry),
    .drain_i (handshake),
    .clear_i (redirect),
    .valid_o (buf_valid),
    .entry_o (buf_entry)
  );

  // bd reflects whether ID holds a branch at the moment it takes this entry.
  always_comb begin
    fs_to_ds_bus              = buf_entry;
    fs_to_ds_bus.exception.bd = buf_valid & ds_br_op;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a stream-level model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            ds_allowin = 1'b0;
  logic            ds_br_op = 1'b0;
  fs_to_ds_bus_t   fs_to_ds_bus;
  logic            br_redirect = 1'b0;
  virt_t           br_target = '0;
  pipeline_flush_t pipeline_flush = '0;
  virt_t           flush_target = '0;
  logic            inst_req;
  logic [31:0]     inst_addr;
  logic            inst_addr_ok = 1'b0;
  logic            inst_data_ok = 1'b0;
  logic [31:0]     inst_rdata = '0;

  if_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .ds_br_op       (ds_br_op),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .br_redirect    (br_redirect),
    .br_target      (br_target),
    .pipeline_flush (pipeline_flush),
    .flush_target   (flush_target),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input virt_t a);
    return {a[15:0] ^ 16'h3C5A, a[31:16] ^ 16'h0F0F};
  endfunction

  function automatic fs_to_ds_bus_t strip_bd(input fs_to_ds_bus_t b);
    fs_to_ds_bus_t r;
    r              = b;
    r.exception.bd = 1'b0;
    return r;
  endfunction

  // Memory model state (one outstanding read, latency k cycles after acceptance).
  logic        mem_out = 1'b0;
  logic        mem_stale = 1'b0;
  virt_t       mem_addr = '0;
  int unsigned mem_cnt = 0;
  int unsigned acc_pct = 100;
  int unsigned k_min = 1;
  int unsigned k_max = 1;

  // Stimulus knobs.
  logic  d_resetn = 1'b0;
  logic  d_allow = 1'b1;
  logic  d_brop = 1'b0;
  logic  arm_wait = 1'b0;
  logic  arm_data = 1'b0;
  logic  fired = 1'b0;
  virt_t arm_tgt = '0;

  // Reference model: next fetch address, next PC ID should receive, AdEL bookkeeping.
  virt_t         req_pc = RESET_PC_DEFAULT;
  virt_t         hand_pc = RESET_PC_DEFAULT;
  logic          adel_given = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_redir = 1'b0;
  logic          expect_valid = 1'b0;
  logic          expect_invalid = 1'b0;
  fs_to_ds_bus_t prev_bus = '0;
  int            hs_count = 0;

  always @(negedge clk) begin
    fs_to_ds_bus_t exp_e;
    logic          redir;
    logic          hs;
    logic          exp_req;
    virt_t         tgt;
    if (!resetn) begin
      check("reset_outputs", 128'({inst_req, fs_to_ds_bus}), 128'(0));
      req_pc         = RESET_PC_DEFAULT;
      hand_pc        = RESET_PC_DEFAULT;
      adel_given     = 1'b0;
      prev_stall     = 1'b0;
      prev_redir     = 1'b0;
      expect_valid   = 1'b0;
      expect_invalid = 1'b0;
      mem_out        = 1'b0;
      mem_stale      = 1'b0;
    end else begin
      redir   = br_redirect || (pipeline_flush != '0);
      tgt     = (pipeline_flush != '0) ? flush_target : br_target;
      hs      = fs_to_ds_bus.valid && ds_allowin;
      exp_req = (req_pc[1:0] == 2'b00) && !mem_out && (!fs_to_ds_bus.valid || ds_allowin);
      check("inst_req", 128'(inst_req), 128'(exp_req));
      if (inst_req) check("inst_addr", 128'(inst_addr), 128'(req_pc));
      if (prev_stall) check("bus_hold", 128'(strip_bd(fs_to_ds_bus)), 128'(strip_bd(prev_bus)));
      if (prev_redir || expect_invalid) check("valid_low", 128'(fs_to_ds_bus.valid), 128'(0));
      if (expect_valid) check("valid_high", 128'(fs_to_ds_bus.valid), 128'(1));
      if (hs) begin
        exp_e = '0;
        if (hand_pc[1:0] != 2'b00) begin
          if (!adel_given) begin
            exp_e.valid              = 1'b1;
            exp_e.pc                 = hand_pc;
            exp_e.exception.ex       = 1'b1;
            exp_e.exception.exccode  = 5'h04;
            exp_e.exception.badvaddr = hand_pc;
            exp_e.exception.bd       = ds_br_op;
          end
          adel_given = 1'b1;
        end else begin
          exp_e.valid        = 1'b1;
          exp_e.inst         = mem_word(hand_pc);
          exp_e.pc           = hand_pc;
          exp_e.exception.bd = ds_br_op;
          hand_pc            = hand_pc + 32'd4;
        end
        check("entry", 128'(fs_to_ds_bus), 128'(exp_e));
        hs_count++;
      end
      prev_stall     = fs_to_ds_bus.valid && !ds_allowin && !redir;
      prev_bus       = fs_to_ds_bus;
      prev_redir     = redir;
      expect_valid   = 1'b0;
      expect_invalid = 1'b0;
      if (mem_out && inst_data_ok) begin
        if (!redir) begin
          if (mem_stale) expect_invalid = 1'b1;
          else expect_valid = 1'b1;
        end
        mem_out = 1'b0;
      end else if (mem_out && mem_cnt != 0) begin
        mem_cnt--;
      end
      if (mem_out && redir) mem_stale = 1'b1;
      if (inst_req && inst_addr_ok) begin
        mem_out   = 1'b1;
        mem_addr  = inst_addr;
        mem_cnt   = $urandom_range(k_max - 1, k_min - 1);
        mem_stale = redir;
        if (!redir) req_pc = req_pc + 32'd4;
      end
      if (redir) begin
        req_pc     = tgt;
        hand_pc    = tgt;
        adel_given = 1'b0;
      end
    end
  end

  task automatic step(input logic br, input pipeline_flush_t fl, input virt_t tgt);
    @(posedge clk);
    #1;
    resetn         = d_resetn;
    inst_data_ok   = mem_out && (mem_cnt == 0);
    inst_rdata     = inst_data_ok ? mem_word(mem_addr) : $urandom;
    inst_addr_ok   = ($urandom_range(99) < acc_pct);
    ds_allowin     = d_allow;
    ds_br_op       = d_brop;
    br_redirect    = br;
    pipeline_flush = fl;
    br_target      = tgt;
    flush_target   = tgt;
    if ((arm_wait && mem_out && !inst_data_ok) || (arm_data && inst_data_ok)) begin
      br_redirect       = 1'b0;
      pipeline_flush    = '0;
      pipeline_flush.ex = 1'b1;
      flush_target      = arm_tgt;
      arm_wait          = 1'b0;
      arm_data          = 1'b0;
      fired             = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic            found;
    pipeline_flush_t fl;
    virt_t           t;
    fs_to_ds_bus_t   held;
    int unsigned     r;

    // Reset: no request, bus idle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0);
      check("rst_req", 128'(inst_req), 128'(0));
      check("rst_bus", 128'(fs_to_ds_bus), 128'(0));
    end

    // Release with k=1: one instruction every second cycle.
    d_resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0);
      if (i % 2 == 0) begin
        check("seq_req", 128'(inst_req), 128'(1));
        check("seq_addr", 128'(inst_addr), 128'(32'hBFC0_0000 + 32'(4 * (i / 2))));
        check("seq_valid", 128'(fs_to_ds_bus.valid), 128'(i >= 2));
        if (i >= 2) check("seq_pc", 128'(fs_to_ds_bus.pc), 128'(32'hBFC0_0000 + 32'(4 * (i / 2 - 1))));
      end else begin
        check("seq_req_wait", 128'(inst_req), 128'(0));
        check("seq_valid_wait", 128'(fs_to_ds_bus.valid), 128'(0));
      end
    end

    // ID stalls for 5 cycles with the buffer full.
    d_allow = 1'b0;
    step(1'b0, '0, '0);
    held = fs_to_ds_bus;
    check("stall_valid", 128'(held.valid), 128'(1));
    check("stall_pc", 128'(held.pc), 128'(32'hBFC0_0008));
    check("stall_req", 128'(inst_req), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0);
      check("stall_req", 128'(inst_req), 128'(0));
      check("stall_bus", 128'(fs_to_ds_bus), 128'(held));
    end
    d_allow = 1'b1;
    k_min   = 3;
    k_max   = 3;
    step(1'b0, '0, '0);
    check("resume_req", 128'(inst_req), 128'(1));
    check("resume_addr", 128'(inst_addr), 128'(32'hBFC0_000C));

    // Exception flush while a fetch is outstanding.
    arm_tgt  = 32'hBFC0_0380;
    arm_wait = 1'b1;
    fired    = 1'b0;
    for (int i = 0; i < 10 && !fired; i++) step(1'b0, '0, '0);
    check("flush_wait_fired", 128'(fired), 128'(1));
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, '0, '0);
      if (fs_to_ds_bus.valid) begin
        found = 1'b1;
        check("flush_pc", 128'(fs_to_ds_bus.pc), 128'(32'hBFC0_0380));
        check("flush_inst", 128'(fs_to_ds_bus.inst), 128'(mem_word(32'hBFC0_0380)));
      end
    end
    check("flush_seen", 128'(found), 128'(1));

    // Branch to a misaligned target: AdEL entry, no fetch.
    k_min = 1;
    k_max = 1;
    step(1'b1, '0, 32'h8000_0102);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0);
      check("adel_noreq", 128'(inst_req), 128'(0));
      if (fs_to_ds_bus.valid && !found) begin
        found = 1'b1;
        check("adel_ex", 128'(fs_to_ds_bus.exception.ex), 128'(1));
        check("adel_code", 128'(fs_to_ds_bus.exception.exccode), 128'(5'h04));
        check("adel_badv", 128'(fs_to_ds_bus.exception.badvaddr), 128'(32'h8000_0102));
        check("adel_inst", 128'(fs_to_ds_bus.inst), 128'(0));
      end
    end
    check("adel_seen", 128'(found), 128'(1));

    // Delay-slot marking on the handshake cycle.
    d_allow = 1'b0;
    step(1'b1, '0, 32'hBFC0_0100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0, '0);
      found = fs_to_ds_bus.valid;
    end
    d_allow = 1'b1;
    d_brop  = 1'b1;
    step(1'b0, '0, '0);
    check("bd_valid", 128'(fs_to_ds_bus.valid), 128'(1));
    check("bd_set", 128'(fs_to_ds_bus.exception.bd), 128'(1));
    check("bd_pc", 128'(fs_to_ds_bus.pc), 128'(32'hBFC0_0100));
    d_brop = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0, '0);
      if (fs_to_ds_bus.valid) begin
        found = 1'b1;
        check("bd_clear", 128'(fs_to_ds_bus.exception.bd), 128'(0));
        check("bd_next_pc", 128'(fs_to_ds_bus.pc), 128'(32'hBFC0_0104));
      end
    end
    check("bd_next_seen", 128'(found), 128'(1));

    // Flush in the same cycle as data_ok: drop data, request again immediately.
    arm_tgt  = 32'hBFC0_0200;
    arm_data = 1'b1;
    fired    = 1'b0;
    for (int i = 0; i < 10 && !fired; i++) step(1'b0, '0, '0);
    check("flush_data_fired", 128'(fired), 128'(1));
    step(1'b0, '0, '0);
    check("fd_req", 128'(inst_req), 128'(1));
    check("fd_addr", 128'(inst_addr), 128'(32'hBFC0_0200));
    check("fd_valid", 128'(fs_to_ds_bus.valid), 128'(0));

    // Randomized traffic.
    acc_pct  = 70;
    k_min    = 1;
    k_max    = 4;
    hs_count = 0;
    for (int i = 0; i < 3000; i++) begin
      d_allow = ($urandom_range(99) < 75);
      d_brop  = ($urandom_range(99) < 30);
      t       = $urandom;
      t[1:0]  = ($urandom_range(9) == 0) ? 2'b10 : 2'b00;
      fl      = '0;
      r       = $urandom_range(99);
      if (r < 2) begin
        step(1'b1, '0, t);
      end else if (r < 4) begin
        fl = pipeline_flush_t'(4'(1 << $urandom_range(3)));
        step(1'b0, fl, t);
      end else begin
        step(1'b0, '0, '0);
      end
    end
    check("progress", 128'(hs_count > 200), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
